// File: rtl/stack_pkg.sv
// Shared sizing constants and write-sequencer state type for the LIFO controller.
package stack_pkg;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int PTR_W = 6;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } wr_state_e;

endpackage

// File: rtl/stack_if.sv
// Host request/response signals plus the latch-array write and readback bus.
interface stack_if;
  import stack_pkg::*;

  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       din;
  logic                   ready;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic                   full;
  logic                   empty;
  logic                   ovf_err;
  logic                   unf_err;
  logic [DEPTH-1:0]       lat_en;
  logic [WIDTH-1:0]       lat_d;
  logic                   arr_clr_n;
  logic [DEPTH*WIDTH-1:0] rd_bus;

  modport master (
    output push, pop, din, rd_bus,
    input  ready, dout, dout_valid, full, empty, ovf_err, unf_err,
           lat_en, lat_d, arr_clr_n
  );

  modport slave (
    input  push, pop, din, rd_bus,
    output ready, dout, dout_valid, full, empty, ovf_err, unf_err,
           lat_en, lat_d, arr_clr_n
  );

endinterface

// File: rtl/stack_row_dec.sv
// Row-pointer to one-hot latch enable decoder, all zeros when disabled.
module stack_row_dec
  import stack_pkg::*;
#(
  parameter int ROW_W = PTR_W,
  parameter int ROWS  = DEPTH
) (
  input  logic [ROW_W-1:0] row,
  input  logic             en,
  output logic [ROWS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int r = 0; r < ROWS; r++) begin
      onehot[r] = en && (row == ROW_W'(r));
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop controller for the latch-based LIFO: pointer, status flags and
// setup/pulse/hold write sequencing toward the storage array.
module stack_ctrl
  import stack_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  stack_if.slave bus
);

  wr_state_e        state, state_next;
  logic [PTR_W-1:0] count, count_next, count_m1;
  logic [PTR_W-1:0] wr_row, wr_row_next;
  logic [IDX_W-1:0] top_idx;
  logic [WIDTH-1:0] rows [DEPTH];
  logic [WIDTH-1:0] top_data, read_data;
  logic [DEPTH-1:0] lat_en_next;
  logic             rst_q, ready, pulse_next;
  logic             start_write, do_read, set_ovf, set_unf;
  logic             full_q, empty_q, ovf_q, unf_q, dv_q;
  logic [WIDTH-1:0] dout_q, lat_d_q;
  logic [DEPTH-1:0] lat_en_q;

  assign ready    = (state == IDLE) && !rst_q;
  assign count_m1 = count - 1'b1;
  assign top_idx  = count_m1[IDX_W-1:0];

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      rows[r] = bus.rd_bus[r*WIDTH +: WIDTH];
    end
  end

  assign top_data = rows[top_idx];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A simultaneous push/pop on a non-empty stack swaps the top row in place.
  always_comb begin
    state_next  = state;
    count_next  = count;
    wr_row_next = wr_row;
    read_data   = top_data;
    start_write = 1'b0;
    do_read     = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    case (state)
      IDLE: begin
        if (ready) begin
          if (bus.push && bus.pop) begin
            do_read = 1'b1;
            if (empty_q) begin
              read_data = bus.din;
            end else begin
              start_write = 1'b1;
              wr_row_next = count_m1;
            end
          end else if (bus.push) begin
            if (full_q) begin
              set_ovf = 1'b1;
            end else begin
              start_write = 1'b1;
              wr_row_next = count;
              count_next  = count + 1'b1;
            end
          end else if (bus.pop) begin
            if (empty_q) begin
              set_unf = 1'b1;
            end else begin
              do_read    = 1'b1;
              count_next = count_m1;
            end
          end
        end
        if (start_write) state_next = WR_SETUP;
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: state_next = WR_HOLD;
      WR_HOLD:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Enables are registered so the latch cells never see decoder glitches.
  assign pulse_next = (state_next == WR_PULSE);

  stack_row_dec u_row_dec (
    .row    (wr_row),
    .en     (pulse_next),
    .onehot (lat_en_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q    <= 1'b1;
      count    <= '0;
      wr_row   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
    end else begin
      rst_q    <= 1'b0;
      count    <= count_next;
      wr_row   <= wr_row_next;
      full_q   <= (count_next == FULL_COUNT);
      empty_q  <= (count_next == '0);
      dv_q     <= do_read;
      lat_en_q <= lat_en_next;
      if (set_ovf)     ovf_q   <= 1'b1;
      if (set_unf)     unf_q   <= 1'b1;
      if (do_read)     dout_q  <= read_data;
      if (start_write) lat_d_q <= bus.din;
    end
  end

  assign bus.ready      = ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.unf_err    = unf_q;
  assign bus.lat_en     = lat_en_q;
  assign bus.lat_d      = lat_d_q;
  assign bus.arr_clr_n  = !rst_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed table, corner sequences and random traffic
// against a queue-based LIFO model, with a latch-array model on the write side.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst;

  stack_if bus_if ();

  stack_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] rd_bus_v;

  always @(negedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (bus_if.arr_clr_n == 1'b0)     mem[r] <= '0;
      else if (bus_if.lat_en[r] == 1'b1) mem[r] <= bus_if.lat_d;
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) rd_bus_v[r*WIDTH +: WIDTH] = mem[r];
  end

  assign bus_if.rd_bus = rd_bus_v;

  int checks   = 0;
  int failures = 0;

  // Reference LIFO: queue contents plus write-sequence phase (0 = idle).
  logic [WIDTH-1:0] mq [$];
  int               m_phase;
  int               m_wr_row;
  bit               m_startup, m_clr, m_dv, m_ovf, m_unf;
  logic [WIDTH-1:0] m_dout, m_lat_d;

  typedef struct {
    logic        rst;
    logic        push;
    logic        pop;
    logic [7:0]  din;
    logic        ready;
    logic        dv;
    logic [7:0]  dout;
    logic        empty;
    logic        full;
    logic [31:0] lat_en;
    logic [7:0]  lat_d;
    logic        clr_n;
  } vec_t;

  vec_t vecs [9];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic o, input logic [7:0] d);
    bit rdy;
    if (r) begin
      mq.delete();
      m_phase = 0; m_startup = 1'b1; m_clr = 1'b0;
      m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_dout = '0; m_lat_d = '0;
      return;
    end
    rdy = (m_phase == 0) && !m_startup;
    m_startup = 1'b0;
    m_clr = 1'b1;
    m_dv = 1'b0;
    if (m_phase != 0) m_phase = (m_phase + 1) % 4;
    if (rdy) begin
      if (p && o) begin
        m_dv = 1'b1;
        if (mq.size() == 0) begin
          m_dout = d;
        end else begin
          m_dout = mq[mq.size()-1];
          mq[mq.size()-1] = d;
          m_wr_row = mq.size() - 1;
          m_lat_d = d;
          m_phase = 1;
        end
      end else if (p) begin
        if (mq.size() == DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          mq.push_back(d);
          m_wr_row = mq.size() - 1;
          m_lat_d = d;
          m_phase = 1;
        end
      end else if (o) begin
        if (mq.size() == 0) m_unf = 1'b1;
        else begin
          m_dout = mq.pop_back();
          m_dv = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [31:0] exp_en;
    exp_en = (m_phase == 2) ? (32'h1 << m_wr_row) : 32'h0;
    compare("ready",      32'(bus_if.ready),      32'((m_phase == 0) && !m_startup));
    compare("dout_valid", 32'(bus_if.dout_valid), 32'(m_dv));
    compare("dout",       32'(bus_if.dout),       32'(m_dout));
    compare("full",       32'(bus_if.full),       32'(mq.size() == DEPTH));
    compare("empty",      32'(bus_if.empty),      32'(mq.size() == 0));
    compare("ovf_err",    32'(bus_if.ovf_err),    32'(m_ovf));
    compare("unf_err",    32'(bus_if.unf_err),    32'(m_unf));
    compare("lat_en",     bus_if.lat_en,          exp_en);
    compare("lat_d",      32'(bus_if.lat_d),      32'(m_lat_d));
    compare("arr_clr_n",  32'(bus_if.arr_clr_n),  32'(m_clr));
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic o, input logic [7:0] d);
    rst = r; bus_if.push = p; bus_if.pop = o; bus_if.din = d;
    model_step(r, p, o, d);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_wait(input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, d);
    idle(3);
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
  endtask

  initial begin
    // rst push pop din | ready dv dout empty full lat_en lat_d clr_n
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 8'hA5, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h1, 8'hA5, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 8'hA5, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 8'hA5, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 32'h0, 8'hA5, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 32'h0, 8'hA5, 1'b1};

    rst = 1'b1; bus_if.push = 1'b0; bus_if.pop = 1'b0; bus_if.din = '0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
      compare($sformatf("vec%0d.ready", i),  32'(bus_if.ready),      32'(vecs[i].ready));
      compare($sformatf("vec%0d.dv", i),     32'(bus_if.dout_valid), 32'(vecs[i].dv));
      compare($sformatf("vec%0d.dout", i),   32'(bus_if.dout),       32'(vecs[i].dout));
      compare($sformatf("vec%0d.empty", i),  32'(bus_if.empty),      32'(vecs[i].empty));
      compare($sformatf("vec%0d.full", i),   32'(bus_if.full),       32'(vecs[i].full));
      compare($sformatf("vec%0d.lat_en", i), bus_if.lat_en,          vecs[i].lat_en);
      compare($sformatf("vec%0d.lat_d", i),  32'(bus_if.lat_d),      32'(vecs[i].lat_d));
      compare($sformatf("vec%0d.clr_n", i),  32'(bus_if.arr_clr_n),  32'(vecs[i].clr_n));
    end

    // Fill to the brim, overflow, then drain back-to-back.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_wait(8'(i));
    compare("fill.full", 32'(bus_if.full), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    compare("fill.ovf_err", 32'(bus_if.ovf_err), 32'h1);
    idle(3);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      compare("drain.dout", 32'(bus_if.dout), 32'(DEPTH - 1 - i));
    end
    compare("drain.empty", 32'(bus_if.empty), 32'h1);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    compare("underflow.unf_err", 32'(bus_if.unf_err), 32'h1);
    compare("underflow.dv", 32'(bus_if.dout_valid), 32'h0);
    push_wait(8'h5A);
    compare("after_unf.empty", 32'(bus_if.empty), 32'h0);

    // Simultaneous push/pop on a two-entry stack rewrites row 1.
    do_reset();
    push_wait(8'h11);
    push_wait(8'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
    compare("swap.dout", 32'(bus_if.dout), 32'h22);
    idle(3);
    #1;
    compare("swap.row1", 32'(mem[1]), 32'h33);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    compare("swap.pop1", 32'(bus_if.dout), 32'h33);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    compare("swap.pop0", 32'(bus_if.dout), 32'h11);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h44);
    compare("bypass.dout", 32'(bus_if.dout), 32'h44);
    compare("bypass.dv", 32'(bus_if.dout_valid), 32'h1);
    idle(3);

    // Reset landing in the middle of a write pulse.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    compare("midrst.pulse", bus_if.lat_en, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    compare("midrst.lat_en", bus_if.lat_en, 32'h0);
    compare("midrst.empty", 32'(bus_if.empty), 32'h1);
    compare("midrst.unf_err", 32'(bus_if.unf_err), 32'h0);
    idle(2);

    // Random traffic: fill-biased half, then drain-biased half.
    for (int i = 0; i < 1200; i++) begin
      int pb;
      pb = (i < 600) ? 70 : 30;
      applyStimulus($urandom_range(0, 149) == 0,
                    $urandom_range(0, 99) < pb,
                    $urandom_range(0, 99) < (100 - pb),
                    8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
